// File: rtl/xbar_rr_sched.sv
// rtl/xbar_rr_sched.sv - round-robin scheduler driving the crossbar output mux selects
//
// Each input names one destination output. Every output runs its own
// IDLE/BUSY arbiter and locks onto one input until that input's transfer ends.
// The select bus and valid flags feed the per-output mux column.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   req    [N_IN]         input i has a beat for dest[i]
//   dest   [N_IN*SEL_W]   dest[i*SEL_W +: SEL_W] = target output of input i
//   last   [N_IN]         beat on input i is the final beat of its transfer
//   gnt    [N_IN]         input i owns an output; a beat moves when req[i]&gnt[i]
//   osel   [N_OUT*SEL_W]  osel[o*SEL_W +: SEL_W] = input routed to output o
//   ovld   [N_OUT]        output o has an owner
//
// Optional feature macro: XBAR_HOLD_TIMEOUT_EN
//   When defined, a per-output beat counter preempts an owner after MAX_HOLD
//   beats if another input is waiting for the same output.

module xbar_rr_sched #(
  parameter int N_IN     = 4,
  parameter int N_OUT    = 4,
  parameter int SEL_W    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN-1:0]        req,
  input  logic [N_IN*SEL_W-1:0]  dest,
  input  logic [N_IN-1:0]        last,
  output logic [N_IN-1:0]        gnt,
  output logic [N_OUT*SEL_W-1:0] osel,
  output logic [N_OUT-1:0]       ovld
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q [N_OUT];
  state_t           state_d [N_OUT];
  logic [SEL_W-1:0] own_q   [N_OUT];
  logic [SEL_W-1:0] own_d   [N_OUT];
  logic [SEL_W-1:0] ptr_q   [N_OUT];
  logic [SEL_W-1:0] ptr_d   [N_OUT];
  logic [SEL_W-1:0] start   [N_OUT];
  logic [SEL_W-1:0] win     [N_OUT];
  logic [N_IN-1:0]  elig    [N_OUT];
  logic             rel     [N_OUT];
  logic             found   [N_OUT];
  logic [N_IN-1:0]  gnt_q;
  logic [N_IN-1:0]  gnt_d;

`ifdef XBAR_HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] cnt_q [N_OUT];
  logic [CNT_W-1:0] cnt_d [N_OUT];
`else
  logic unused_max_hold;
  assign unused_max_hold = |MAX_HOLD;
`endif

  always_comb begin
    int idx;
    idx   = 0;
    gnt_d = '0;
    for (int o = 0; o < N_OUT; o++) begin
      state_d[o] = state_q[o];
      own_d[o]   = own_q[o];
      ptr_d[o]   = ptr_q[o];
      found[o]   = 1'b0;
      win[o]     = '0;

      // Inputs already holding a grant (including one releasing on this edge)
      // are excluded, so a released owner can only re-win on a later edge.
      // Destinations >= N_OUT never match any output index.
      for (int i = 0; i < N_IN; i++) begin
        elig[o][i] = req[i] && !gnt_q[i] &&
                     (dest[i*SEL_W +: SEL_W] == SEL_W'(o));
      end

      // Owner finishes on its last beat or aborts by dropping req.
      rel[o] = (state_q[o] == BUSY) &&
               (!req[own_q[o]] || last[own_q[o]]);

`ifdef XBAR_HOLD_TIMEOUT_EN
      cnt_d[o] = cnt_q[o];
      if ((state_q[o] == BUSY) && req[own_q[o]] &&
          (cnt_q[o] != CNT_W'(MAX_HOLD))) begin
        cnt_d[o] = cnt_q[o] + 1'b1;
      end
      // Preempt only on an owner beat that reaches the limit with a waiter.
      if ((state_q[o] == BUSY) && req[own_q[o]] &&
          (cnt_d[o] == CNT_W'(MAX_HOLD)) && (|elig[o])) begin
        rel[o] = 1'b1;
      end
`endif

      // On release the search starts just past the departing owner.
      if (rel[o]) begin
        start[o] = (own_q[o] == SEL_W'(N_IN - 1)) ? '0 : own_q[o] + 1'b1;
        ptr_d[o] = start[o];
      end else begin
        start[o] = ptr_q[o];
      end

      // Walk from the highest offset down so the first hit at or after
      // start (mod N_IN) is what remains.
      for (int k = N_IN - 1; k >= 0; k--) begin
        idx = int'(start[o]) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        if (elig[o][idx]) begin
          found[o] = 1'b1;
          win[o]   = SEL_W'(idx);
        end
      end

      if ((state_q[o] == IDLE) || rel[o]) begin
        if (found[o]) begin
          state_d[o] = BUSY;
          own_d[o]   = win[o];
`ifdef XBAR_HOLD_TIMEOUT_EN
          cnt_d[o]   = '0;
`endif
        end else begin
          state_d[o] = IDLE;
        end
      end

      if (state_d[o] == BUSY) gnt_d[own_d[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      for (int o = 0; o < N_OUT; o++) begin
        state_q[o] <= IDLE;
        own_q[o]   <= '0;
        ptr_q[o]   <= '0;
`ifdef XBAR_HOLD_TIMEOUT_EN
        cnt_q[o]   <= '0;
`endif
      end
    end else begin
      gnt_q <= gnt_d;
      for (int o = 0; o < N_OUT; o++) begin
        state_q[o] <= state_d[o];
        own_q[o]   <= own_d[o];
        ptr_q[o]   <= ptr_d[o];
`ifdef XBAR_HOLD_TIMEOUT_EN
        cnt_q[o]   <= cnt_d[o];
`endif
      end
    end
  end

  assign gnt = gnt_q;

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    assign osel[o*SEL_W +: SEL_W] = own_q[o];
    assign ovld[o]                = (state_q[o] == BUSY);
  end

endmodule

// File: tb/tb_xbar_rr_sched.sv
// tb/tb_xbar_rr_sched.sv - self-checking bench for xbar_rr_sched

module tb_xbar_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] last = '0;
  logic [7:0] dest = '0;

  logic [3:0] gnt;
  logic [7:0] osel;
  logic [3:0] ovld;
  logic [3:0] gnt3;
  logic [5:0] osel3;
  logic [2:0] ovld3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [3:0] ovld;
    logic [7:0] osel;
    bit         chk3;
    logic [3:0] gnt3;
    logic [2:0] ovld3;
    logic [5:0] osel3;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  xbar_rr_sched #(.N_IN(4), .N_OUT(4), .SEL_W(2), .MAX_HOLD(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dest(dest), .last(last),
    .gnt(gnt), .osel(osel), .ovld(ovld)
  );

  xbar_rr_sched #(.N_IN(4), .N_OUT(3), .SEL_W(2), .MAX_HOLD(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .dest(dest), .last(last),
    .gnt(gnt3), .osel(osel3), .ovld(ovld3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] sel_mask(input logic [3:0] v);
    logic [7:0] m;
    m = '0;
    for (int o = 0; o < 4; o++) if (v[o]) m[o*2 +: 2] = 2'b11;
    return m;
  endfunction

  task automatic compare();
    exp_t       e;
    logic [7:0] m;
    logic [7:0] m3;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    m = sel_mask(e.ovld);
    check({e.tag, ".gnt"},  32'(gnt),  32'(e.gnt));
    check({e.tag, ".ovld"}, 32'(ovld), 32'(e.ovld));
    check({e.tag, ".osel"}, 32'(osel & m), 32'(e.osel & m));
    if (e.chk3) begin
      m3 = sel_mask({1'b0, e.ovld3});
      check({e.tag, ".gnt3"},  32'(gnt3),  32'(e.gnt3));
      check({e.tag, ".ovld3"}, 32'(ovld3), 32'(e.ovld3));
      check({e.tag, ".osel3"}, 32'(osel3 & m3[5:0]), 32'(e.osel3 & m3[5:0]));
    end
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic [7:0] d,
                      input logic [3:0] l, input logic [3:0] eg, input logic [3:0] ev,
                      input logic [7:0] es, input bit c3 = 1'b0,
                      input logic [3:0] eg3 = '0, input logic [2:0] ev3 = '0,
                      input logic [5:0] es3 = '0);
    exp_t e;
    req  = r;
    dest = d;
    last = l;
    e.tag = tag;   e.gnt = eg;    e.ovld = ev;    e.osel = es;
    e.chk3 = c3;   e.gnt3 = eg3;  e.ovld3 = ev3;  e.osel3 = es3;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".gnt"},   32'(gnt),   32'd0);
    check({tag, ".ovld"},  32'(ovld),  32'd0);
    check({tag, ".osel"},  32'(osel),  32'd0);
    check({tag, ".gnt3"},  32'(gnt3),  32'd0);
    check({tag, ".ovld3"}, 32'(ovld3), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    req   = '0;
    last  = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_cleared(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int nb;

    // Reset held with every input requesting its own output.
    req   = 4'hF;
    dest  = 8'hE4;
    last  = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_cleared("t1_in_reset");
    rst_n = 1'b1;
    #1;
    check("t1_no_gnt_before_edge", 32'(gnt), 32'd0);
    step("t1_first", 4'hF, 8'hE4, 4'h0, 4'hF, 4'hF, 8'hE4);

    // Four single-beat requesters on output 2 rotate without bubbles.
    do_reset("t2_rst");
    step("t2_rr0", 4'hF, 8'hAA, 4'hF, 4'b0001, 4'b0100, 8'h00);
    step("t2_rr1", 4'hF, 8'hAA, 4'hF, 4'b0010, 4'b0100, 8'h10);
    step("t2_rr2", 4'hF, 8'hAA, 4'hF, 4'b0100, 4'b0100, 8'h20);
    step("t2_rr3", 4'hF, 8'hAA, 4'hF, 4'b1000, 4'b0100, 8'h30);
    step("t2_idle", 4'h0, 8'hAA, 4'h0, 4'b0000, 4'b0000, 8'h00);

    // Input 1 holds output 0 for five beats while input 3 waits.
    do_reset("t3_rst");
    step("t3_grant", 4'b0010, 8'h00, 4'b0000, 4'b0010, 4'b0001, 8'h01);
    step("t3_beat1", 4'b0010, 8'h00, 4'b0000, 4'b0010, 4'b0001, 8'h01);
    step("t3_beat2", 4'b1010, 8'h00, 4'b0000, 4'b0010, 4'b0001, 8'h01);
    step("t3_beat3", 4'b1010, 8'h00, 4'b0000, 4'b0010, 4'b0001, 8'h01);
    step("t3_beat4", 4'b1010, 8'h00, 4'b0000, 4'b0010, 4'b0001, 8'h01);
    step("t3_beat5", 4'b1010, 8'h00, 4'b0010, 4'b1000, 4'b0001, 8'h03);
    step("t3_single", 4'b1000, 8'h00, 4'b1000, 4'b0000, 4'b0000, 8'h00);

    // Parallel grants; input 0 aborts while output 1 carries on.
    do_reset("t4_rst");
    step("t4_par",   4'b0101, 8'h13, 4'b0000, 4'b0101, 4'b1010, 8'h08);
    step("t4_hold",  4'b0101, 8'h13, 4'b0000, 4'b0101, 4'b1010, 8'h08);
    step("t4_abort", 4'b0100, 8'h13, 4'b0000, 4'b0100, 4'b0010, 8'h08);
    step("t4_keep",  4'b0100, 8'h13, 4'b0000, 4'b0100, 4'b0010, 8'h08);
    step("t4_end",   4'b0100, 8'h13, 4'b0100, 4'b0000, 4'b0000, 8'h00);

    // dest=3 is out of range on the 3-output instance; then async reset while busy.
    do_reset("t5_rst");
    step("t5_a", 4'b0011, 8'h0C, 4'b0000, 4'b0011, 4'b1001, 8'h40, 1'b1, 4'b0001, 3'b001, 6'h00);
    step("t5_b", 4'b0011, 8'h0C, 4'b0000, 4'b0011, 4'b1001, 8'h40, 1'b1, 4'b0001, 3'b001, 6'h00);
    step("t5_c", 4'b0011, 8'h0C, 4'b0000, 4'b0011, 4'b1001, 8'h40, 1'b1, 4'b0001, 3'b001, 6'h00);
    rst_n = 1'b0;
    #1;
    check_cleared("t5_async");
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Long stream from input 0 on output 1 with input 2 waiting.
    do_reset("t6_rst");
    step("t6_grant", 4'b0001, 8'h11, 4'b0000, 4'b0001, 4'b0010, 8'h00);
`ifdef XBAR_HOLD_TIMEOUT_EN
    nb = 8;
`else
    nb = 20;
`endif
    for (int b = 1; b <= nb; b++) begin
`ifdef XBAR_HOLD_TIMEOUT_EN
      if (b < nb) step("t6_beat", 4'b0101, 8'h11, 4'b0000, 4'b0001, 4'b0010, 8'h00);
      else        step("t6_switch", 4'b0101, 8'h11, 4'b0000, 4'b0100, 4'b0010, 8'h08);
`else
      if (b < nb) step("t6_beat", 4'b0101, 8'h11, 4'b0000, 4'b0001, 4'b0010, 8'h00);
      else        step("t6_switch", 4'b0101, 8'h11, 4'b0001, 4'b0100, 4'b0010, 8'h08);
`endif
    end
    step("t6_end", 4'b0100, 8'h11, 4'b0100, 4'b0000, 4'b0000, 8'h00);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
